// File: rtl/multichannel_comm.sv
// Byte-serial framer/deframer: carries {len, ch} headed messages for several logical
// channels over one UART byte-FIFO interface. RX and TX paths are independent.
module multichannel_comm #(
    parameter int CHANNEL_BIT = 1,
    parameter int MESSAGE_BIT = 72
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          send_flag,
    output logic [7:0]                    send_data,
    output logic                          recv_flag,
    input  logic [7:0]                    recv_data,
    input  logic                          sendable,
    input  logic                          recvable,
    input  logic [(1<<CHANNEL_BIT)-1:0]   read_flag,
    output logic [4+MESSAGE_BIT:0]        read_out,
    input  logic [(1<<CHANNEL_BIT)-1:0]   write_flag,
    input  logic [4+MESSAGE_BIT:0]        write_in,
    output logic [(1<<CHANNEL_BIT)-1:0]   readable,
    output logic [(1<<CHANNEL_BIT)-1:0]   writable
);

    localparam int N      = 1 << CHANNEL_BIT;
    localparam int MAXLEN = MESSAGE_BIT / 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PAYLOAD,
        RX_HOLD
    } rx_state_t;

    rx_state_t              rx_state_q, rx_state_d;
    logic [4:0]             rx_len_q, rx_len_d;
    logic [4:0]             rx_cnt_q, rx_cnt_d;
    logic [CHANNEL_BIT-1:0] rx_ch_q, rx_ch_d;
    logic [MESSAGE_BIT-1:0] rx_data_q, rx_data_d;
    logic                   recv_flag_q, recv_flag_d;

    logic [4:0]             hdr_len;
    logic                   hdr_ok;

    assign hdr_len = recv_data[7:3];
    // Headers naming a channel that does not exist are dropped like bad lengths.
    assign hdr_ok  = (hdr_len != 5'd0) && (hdr_len <= 5'(MAXLEN)) &&
                     (32'(recv_data[2:0]) < N);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_len_d   = rx_len_q;
        rx_cnt_d   = rx_cnt_q;
        rx_ch_d    = rx_ch_q;
        rx_data_d  = rx_data_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (recv_flag_q && hdr_ok) begin
                    rx_len_d   = hdr_len;
                    rx_ch_d    = recv_data[CHANNEL_BIT-1:0];
                    rx_data_d  = '0;
                    rx_cnt_d   = '0;
                    rx_state_d = RX_PAYLOAD;
                end
            end
            RX_PAYLOAD: begin
                if (recv_flag_q) begin
                    for (int i = 0; i < MAXLEN; i++) begin
                        if (rx_cnt_q == 5'(i)) rx_data_d[8*i +: 8] = recv_data;
                    end
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_d == rx_len_q) rx_state_d = RX_HOLD;
                end
            end
            RX_HOLD: begin
                if (read_flag[rx_ch_q]) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // The pop is registered, so the UART status gets a cycle to update between pops.
        recv_flag_d = recvable && !recv_flag_q && (rx_state_q != RX_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_len_q    <= '0;
            rx_cnt_q    <= '0;
            rx_ch_q     <= '0;
            rx_data_q   <= '0;
            recv_flag_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_len_q    <= rx_len_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_ch_q     <= rx_ch_d;
            rx_data_q   <= rx_data_d;
            recv_flag_q <= recv_flag_d;
        end
    end

    assign recv_flag = recv_flag_q;

    always_comb begin
        readable = '0;
        read_out = '0;
        if (rx_state_q == RX_HOLD) begin
            readable[rx_ch_q] = ~read_flag[rx_ch_q];
            read_out          = {rx_len_q, rx_data_q};
        end
    end

    logic                   tx_busy_q, tx_busy_d;
    logic [5:0]             tx_idx_q, tx_idx_d;
    logic [4:0]             tx_len_q, tx_len_d;
    logic [CHANNEL_BIT-1:0] tx_ch_q, tx_ch_d;
    logic [MESSAGE_BIT-1:0] tx_data_q, tx_data_d;
    logic                   send_flag_q, send_flag_d;
    logic [7:0]             send_data_q, send_data_d;

    logic [4:0]             wr_len, wr_len_c;
    logic [CHANNEL_BIT-1:0] wr_ch;
    logic [2:0]             wr_ch_ext, tx_ch_ext;

    always_comb begin
        wr_len   = write_in[MESSAGE_BIT+4:MESSAGE_BIT];
        wr_len_c = ((wr_len == 5'd0) || (wr_len > 5'(MAXLEN))) ? 5'(MAXLEN) : wr_len;
        wr_ch    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (write_flag[i]) wr_ch = CHANNEL_BIT'(i);
        end
        wr_ch_ext                  = '0;
        wr_ch_ext[CHANNEL_BIT-1:0] = wr_ch;
        tx_ch_ext                  = '0;
        tx_ch_ext[CHANNEL_BIT-1:0] = tx_ch_q;
    end

    // tx_idx counts bytes issued: 0 = header pending, len+1 = last payload byte issued.
    always_comb begin
        tx_busy_d   = tx_busy_q;
        tx_idx_d    = tx_idx_q;
        tx_len_d    = tx_len_q;
        tx_ch_d     = tx_ch_q;
        tx_data_d   = tx_data_q;
        send_flag_d = 1'b0;
        send_data_d = send_data_q;
        if (!tx_busy_q) begin
            if (|write_flag) begin
                tx_busy_d = 1'b1;
                tx_len_d  = wr_len_c;
                tx_ch_d   = wr_ch;
                tx_data_d = write_in[MESSAGE_BIT-1:0];
                tx_idx_d  = '0;
                if (sendable && !send_flag_q) begin
                    send_flag_d = 1'b1;
                    send_data_d = {wr_len_c, wr_ch_ext};
                    tx_idx_d    = 6'd1;
                end
            end
        end else if (send_flag_q && (tx_idx_q == ({1'b0, tx_len_q} + 6'd1))) begin
            tx_busy_d = 1'b0;
        end else if (sendable && !send_flag_q) begin
            send_flag_d = 1'b1;
            tx_idx_d    = tx_idx_q + 6'd1;
            if (tx_idx_q == 6'd0) begin
                send_data_d = {tx_len_q, tx_ch_ext};
            end else begin
                send_data_d = tx_data_q[7:0];
                tx_data_d   = tx_data_q >> 8;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q   <= 1'b0;
            tx_idx_q    <= '0;
            tx_len_q    <= '0;
            tx_ch_q     <= '0;
            tx_data_q   <= '0;
            send_flag_q <= 1'b0;
            send_data_q <= '0;
        end else begin
            tx_busy_q   <= tx_busy_d;
            tx_idx_q    <= tx_idx_d;
            tx_len_q    <= tx_len_d;
            tx_ch_q     <= tx_ch_d;
            tx_data_q   <= tx_data_d;
            send_flag_q <= send_flag_d;
            send_data_q <= send_data_d;
        end
    end

    assign send_flag = send_flag_q;
    assign send_data = send_data_q;
    assign writable  = {N{~tx_busy_q}};

endmodule

// File: tb/tb_multichannel_comm.sv
// Bench for multichannel_comm: UART FIFO model on the RX side, expected-byte queue on
// the TX side, both derived from the frame format rather than the RTL structure.
module tb_multichannel_comm;

    localparam int CB     = 1;
    localparam int MB     = 72;
    localparam int N      = 2;
    localparam int MAXLEN = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            send_flag;
    logic [7:0]      send_data;
    logic            recv_flag;
    logic [7:0]      recv_data = 8'h00;
    logic            sendable = 1'b1;
    logic            recvable = 1'b0;
    logic [N-1:0]    read_flag = '0;
    logic [4+MB:0]   read_out;
    logic [N-1:0]    write_flag = '0;
    logic [4+MB:0]   write_in = '0;
    logic [N-1:0]    readable;
    logic [N-1:0]    writable;

    multichannel_comm #(.CHANNEL_BIT(CB), .MESSAGE_BIT(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_flag  (send_flag),
        .send_data  (send_data),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .sendable   (sendable),
        .recvable   (recvable),
        .read_flag  (read_flag),
        .read_out   (read_out),
        .write_flag (write_flag),
        .write_in   (write_in),
        .readable   (readable),
        .writable   (writable)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    logic       prev_send = 1'b0;
    logic       prev_recv = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART model: byte FIFO popped on recv_flag; TX bytes compared against expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (send_flag) begin
                check("tx_gap", 128'(prev_send), 0);
                check("tx_byte_expected", 128'(tx_exp.size() != 0), 1);
                if (tx_exp.size() != 0) check("tx_byte", 128'(send_data), 128'(tx_exp.pop_front()));
            end
            if (recv_flag) begin
                check("rx_gap", 128'(prev_recv), 0);
                check("rx_pop_recvable", 128'(recvable), 1);
            end
        end
        prev_send = send_flag;
        prev_recv = recv_flag;
        recvable  = (rx_q.size() != 0);
        recv_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (recv_flag && rx_q.size() != 0) void'(rx_q.pop_front());
    end

    function automatic logic [4+MB:0] exp_msg(input int len, input logic [MB-1:0] data);
        logic [MB-1:0] d = '0;
        for (int i = 0; i < len; i++) d = d | (MB'(data[8*i +: 8]) << (8*i));
        return {5'(len), d};
    endfunction

    task automatic rx_push_frame(input int ch, input int len, input logic [MB-1:0] data);
        rx_q.push_back({5'(len), 3'(ch)});
        for (int i = 0; i < len; i++) rx_q.push_back(data[8*i +: 8]);
    endtask

    task automatic read_msg(input string tag, input int ch, input int len, input logic [MB-1:0] data);
        int n = 0;
        while (readable == '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 128'(n < 500), 1);
        check({tag, "_readable"}, 128'(readable), 128'(1 << ch));
        check({tag, "_read_out"}, 128'(read_out), 128'(exp_msg(len, data)));
        @(posedge clk);
        #1 read_flag = N'(1 << ch);
        #1 check({tag, "_readable_drop"}, 128'(readable), 0);
        @(posedge clk);
        #1 read_flag = '0;
    endtask

    task automatic no_readable(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (readable != '0) seen++;
        end
        check(tag, 128'(seen), 0);
    endtask

    task automatic do_write(input string tag, input logic [N-1:0] flag, input int len,
                            input logic [MB-1:0] data);
        bit accept;
        int l;
        int ch;
        @(posedge clk);
        #1;
        accept     = (tx_exp.size() == 0);
        write_flag = flag;
        write_in   = {5'(len), data};
        if (accept) begin
            l  = (len == 0 || len > MAXLEN) ? MAXLEN : len;
            ch = 0;
            for (int i = N - 1; i >= 0; i--) if (flag[i]) ch = i;
            tx_exp.push_back({5'(l), 3'(ch)});
            for (int i = 0; i < l; i++) tx_exp.push_back(data[8*i +: 8]);
        end
        @(posedge clk);
        #1 write_flag = '0;
        check({tag, "_writable_busy"}, 128'(writable), 0);
    endtask

    task automatic wait_tx_done(input string tag, input bit rand_send);
        int n = 0;
        while (tx_exp.size() != 0 && n < 3000) begin
            @(negedge clk);
            if (rand_send) sendable = ($urandom_range(0, 2) != 0);
            n++;
        end
        sendable = 1'b1;
        check({tag, "_tx_timeout"}, 128'(n < 3000), 1);
        @(posedge clk);
        #1 check({tag, "_writable_free"}, 128'(writable), 128'({N{1'b1}}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_send_flag"}, 128'(send_flag), 0);
        check({tag, "_send_data"}, 128'(send_data), 0);
        check({tag, "_recv_flag"}, 128'(recv_flag), 0);
        check({tag, "_read_out"}, 128'(read_out), 0);
        check({tag, "_readable"}, 128'(readable), 0);
        check({tag, "_writable"}, 128'(writable), 128'({N{1'b1}}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int             pulses;
        int             ch;
        int             len;
        logic [MB-1:0]  data;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback read request: header 0x28 = ch0 len5.
        rx_push_frame(0, 5, 72'h0000000100);
        read_msg("loopback", 0, 5, 72'h0000000100);
        check("loopback_const", 128'(exp_msg(5, 72'h0000000100)), 128'({5'd5, 72'h0000000100}));
        no_readable("loopback_once", 12);

        // Write 4 bytes on ch0: 0x20,0x31,0x00,0x00,0x00.
        do_write("wr4", 2'b01, 4, 72'h31);
        wait_tx_done("wr4", 1'b0);

        // Back-pressure while a message is held.
        rx_push_frame(1, 3, 72'hC0FFEE);
        rx_push_frame(0, 2, 72'h5A5A);
        pulses = 0;
        for (int i = 0; i < 500 && readable == '0; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (recv_flag) pulses++;
        end
        check("bp_no_pop", 128'(pulses), 0);
        check("bp_fifo_kept", 128'(rx_q.size()), 3);
        read_msg("bp_first", 1, 3, 72'hC0FFEE);
        read_msg("bp_second", 0, 2, 72'h5A5A);

        // Bad headers dropped, following frame delivered.
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h50);
        rx_q.push_back(8'h09);
        rx_q.push_back(8'hAB);
        read_msg("badhdr", 1, 1, 72'hAB);
        no_readable("badhdr_after", 10);

        // Randomised RX frames with occasional bad headers.
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) == 0)
                rx_q.push_back(($urandom_range(0, 1) != 0) ? 8'(3'($urandom_range(0, 1)))
                                                           : {5'($urandom_range(10, 31)), 3'd0});
            ch   = $urandom_range(0, 1);
            len  = $urandom_range(1, MAXLEN);
            data = MB'({$urandom(), $urandom(), $urandom()});
            rx_push_frame(ch, len, data);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            read_msg("rx_rand", ch, len, data);
        end

        // TX stall: sendable drops after the header, busy write ignored.
        do_write("stall", 2'b10, 3, 72'h332211);
        sendable = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_flag) pulses++;
        end
        check("stall_held", 128'(pulses), 1);
        check("stall_remaining", 128'(tx_exp.size()), 3);
        do_write("stall_busy_write", 2'b01, 2, 72'hFFFF);
        check("stall_still_held", 128'(tx_exp.size()), 3);
        sendable = 1'b1;
        wait_tx_done("stall", 1'b0);

        // Channel priority and length clamping.
        do_write("clamp0", 2'b11, 0, 72'h998877665544332211);
        wait_tx_done("clamp0", 1'b0);
        do_write("clamp20", 2'b10, 20, 72'h0102030405060708AA);
        wait_tx_done("clamp20", 1'b1);

        for (int k = 0; k < 6; k++) begin
            do_write("tx_rand", N'($urandom_range(1, 3)), $urandom_range(0, 31),
                     MB'({$urandom(), $urandom(), $urandom()}));
            wait_tx_done("tx_rand", 1'b1);
        end

        // Reset in the middle of an RX frame and a TX frame.
        rx_q.push_back(8'h28);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        do_write("midrst", 2'b01, 9, 72'h112233445566778899);
        for (int i = 0; i < 200 && (rx_q.size() != 0 || tx_exp.size() > 7); i++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tx_exp.delete();
        rx_q.delete();
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst_held");
        rst = 1'b0;
        no_readable("midrst_no_spurious", 10);
        rx_push_frame(1, 2, 72'hBBAA);
        read_msg("midrst_rx", 1, 2, 72'hBBAA);
        do_write("midrst_tx", 2'b10, 2, 72'h7766);
        wait_tx_done("midrst_tx", 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multichannel_comm.md
Name: multichannel_comm

Overview:
- Frames and deframes fixed-maximum-size messages for several logical channels over one byte-serial link (UART byte FIFO interface).
- Sits between a UART byte transceiver and client logic, e.g. a memory model or a CPU bus bridge.
- RX bytes are assembled into messages tagged with a channel. TX messages from a channel are serialized into bytes.

Parameters:
- CHANNEL_BIT, 1, channel index width. Channel count N = 2**CHANNEL_BIT. Legal range 1..3.
- MESSAGE_BIT, 72, maximum payload width. Must be a multiple of 8. MAXLEN = MESSAGE_BIT/8, legal range 1..31.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- send_flag  out  1  one-cycle pulse that pushes send_data to the UART.
- send_data  out  8  TX byte.
- recv_flag  out  1  one-cycle pulse that pops recv_data from the UART.
- recv_data  in  8  RX byte at the head of the UART receive FIFO.
- sendable  in  1  UART can accept a byte.
- recvable  in  1  UART holds a received byte.
- read_flag  in  N  client consumes the presented RX message of channel c (bit c).
- read_out  out  5+MESSAGE_BIT  {length[4:0], data} of the RX message currently presented.
- write_flag  in  N  client submits write_in for channel c (bit c).
- write_in  in  5+MESSAGE_BIT  {length[4:0], data} of the TX message.
- readable  out  N  an RX message for channel c is presented.
- writable  out  N  the TX buffer can accept a message for channel c.

Behaviour:
- Frame format: one header byte {len[4:0], ch[2:0]}, with ch zero-extended. The header is followed by len payload bytes, least-significant byte first (byte0 is data[7:0]).
- Reset (async): send_flag=0, send_data=0, recv_flag=0, read_out=0, readable=0, writable=all ones. RX FSM goes to IDLE and the TX buffer is emptied. A partially received or partially sent frame is abandoned.
- UART handshake:
  - recv_flag is asserted only when recvable=1. The byte is taken from recv_data on the same edge.
  - send_flag is asserted only when sendable=1.
  - Each flag is a one-cycle pulse, with at least one idle cycle between pulses so the UART status can update.
- RX FSM:
  - IDLE: on a popped byte, decode len and ch.
    - If len is 0 or len > MAXLEN, drop the header and stay in IDLE.
    - Otherwise clear the assembly register to 0 and go to PAYLOAD with count=0.
  - PAYLOAD: on each popped byte, write it to data[8*count+7 : 8*count] and increment count. When count reaches len, go to HOLD.
  - HOLD: read_out = {len, data} with unused upper bits zero. readable[ch]=1, all other bits 0. No bytes are popped, which back-pressures the UART FIFO.
  - HOLD exit: when read_flag[ch]=1 is sampled, go to IDLE on that edge.
  - readable[ch] = HOLD & ~read_flag[ch], combinationally. A client that registers its read_flag therefore never sees the same message twice.
  - read_flag bits of other channels are ignored.
- TX path:
  - Single-entry buffer. writable = all ones when the buffer is empty, all zeros while it is busy.
  - When write_flag has any bit set and the buffer is empty, latch write_in and the lowest set channel index. Other simultaneous bits are dropped.
  - write_flag while busy is ignored.
  - A length of 0 or greater than MAXLEN is clamped to MAXLEN.
  - Serialization: the header is sent first, then payload bytes LSB first. Each byte waits for sendable. The buffer frees (writable=1) the cycle after the last send_flag.
  - The earliest header send_flag is the cycle after the write.
- RX and TX are fully independent and may operate simultaneously.
- Reset mid-frame: both paths restart clean, with no spurious readable and no spurious send_flag pulse.

Test Plan:
- Loopback read request: UART delivers 0x28, 0x00,0x01,0x00,0x00, 0x00 (ch0, len5).
  - Required: readable=01, read_out = {5, 72'h0000000100}.
  - A registered read_flag drops readable immediately. Exactly one message is seen.
- Write 4 bytes on ch0: write_in = {4, 32'h00000031}, write_flag=01, sendable=1.
  - Required: bytes 0x20,0x31,0x00,0x00,0x00 in order, one send_flag each with gaps between pulses. writable is 0 until done.
- Back-pressure:
  - Hold the RX message unread for 50 cycles while recvable=1. Required: recv_flag stays 0.
  - After read_flag, the next frame is received.
- Bad header: header 0x00 or 0x50 (len10 > 9).
  - Required: the header is dropped, no readable.
  - The following valid frame on ch1 (header 0x09, 1 byte 0xAB) gives readable=10, read_out data = 0xAB.
- TX stall: sendable=0 after the header.
  - Required: send_flag is held off, and bytes resume in order when sendable returns.
  - A write_flag while busy is ignored.
- Reset mid-frame: assert rst after 2 payload bytes.
  - Required: all outputs go to reset values. A new full frame decodes correctly.
